uart_tx_arbiter: RTL and testbench

//   Shares the UART wrapper's single transmit path (trmt/resp/tx_done) between
//   NUM_REQ requesters (e.g. command ack, status reporter, error logger).

---
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit path among NUM_REQ requesters.
// Latches the granted byte, pulses trmt, then reports done or timeout to the owner.
module uart_tx_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int TIMEOUT = 8192,
    localparam int IDW     = $clog2(NUM_REQ),
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     err,
    output logic                   trmt,
    output logic [7:0]             resp,
    input  logic                   tx_done,
    output logic                   busy,
    output logic [IDW-1:0]         gnt_id
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_e;

    state_e               state_q, state_d;
    logic [7:0]           resp_q, resp_d;
    logic [IDW-1:0]       gnt_q, gnt_d;
    logic [IDW-1:0]       rr_q, rr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic                 txd_q;

    logic                 txEdge;
    logic                 timedOut;
    logic                 found;
    logic [IDW-1:0]       sel;
    logic [IDW-1:0]       rrNext;
    int                   idx;

    assign txEdge   = tx_done & ~txd_q;
    assign timedOut = (cnt_q == CW'(TIMEOUT - 1));
    assign rrNext   = (int'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + 1'b1;

    // Scan downwards so the requester closest to rr_q wins the last assignment.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (req[idx]) begin
                sel   = IDW'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (found) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT:   if (txEdge || timedOut) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        trmt = (state_q == S_LAUNCH);
        busy = (state_q != S_IDLE);
        ack  = '0;
        if (state_q == S_LAUNCH) ack[gnt_q] = 1'b1;
        done   = done_q;
        err    = err_q;
        resp   = resp_q;
        gnt_id = gnt_q;
    end

    // A tx_done edge takes priority over a timeout landing in the same cycle.
    always_comb begin
        resp_d = resp_q;
        gnt_d  = gnt_q;
        rr_d   = rr_q;
        cnt_d  = cnt_q;
        done_d = '0;
        err_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    resp_d = req_data[8*int'(sel) +: 8];
                    gnt_d  = sel;
                end
            end
            S_LAUNCH: cnt_d = '0;
            S_WAIT: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                if (txEdge) begin
                    done_d[gnt_q] = 1'b1;
                    rr_d          = rrNext;
                end else if (timedOut) begin
                    err_d[gnt_q] = 1'b1;
                    rr_d         = rrNext;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q <= 8'h00;
            gnt_q  <= '0;
            rr_q   <= '0;
            cnt_q  <= '0;
            done_q <= '0;
            err_q  <= '0;
            txd_q  <= 1'b0;
        end else begin
            resp_q <= resp_d;
            gnt_q  <= gnt_d;
            rr_q   <= rr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            err_q  <= err_d;
            txd_q  <= tx_done;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected grants are queued when requests
// are driven and popped when the DUT acknowledges.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] reqData;
    logic [3:0]  ack, done, err;
    logic        trmt;
    logic [7:0]  resp;
    logic        txDone;
    logic        busy;
    logic [1:0]  gntId;

    typedef struct packed { logic [1:0] id; logic [7:0] data; } exp_t;
    exp_t expQ[$];
    int errors = 0;
    int checks = 0;
    logic [7:0] accum;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(reqData),
        .ack(ack), .done(done), .err(err), .trmt(trmt), .resp(resp),
        .tx_done(txDone), .busy(busy), .gnt_id(gntId)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        req = r;
    endtask

    task automatic pushExp(input logic [1:0] id, input logic [7:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic waitGrant();
        int n = 0;
        while (ack == 4'b0 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("grantSeen", {31'b0, ack != 4'b0}, 32'd1);
    endtask

    // Called in the LAUNCH cycle; the requester drops its line on ack.
    task automatic checkGrant();
        exp_t e;
        checkOutput("sbNotEmpty", {31'b0, expQ.size() != 0}, 32'd1);
        if (expQ.size() == 0) return;
        e = expQ.pop_front();
        checkOutput("ack", ack, 32'd1 << e.id);
        checkOutput("gntId", gntId, e.id);
        checkOutput("resp", resp, e.data);
        checkOutput("trmt", trmt, 1);
        checkOutput("busyHigh", busy, 1);
        checkOutput("noPulsesInLaunch", {done, err}, 0);
        req[e.id] = 1'b0;
    endtask

    // Raises tx_done so its edge is seen in WAIT with counter value n-1.
    task automatic finishByte(input logic [1:0] id, input int n, input bit dropTx);
        tick();
        checkOutput("ackOneCycle", ack, 0);
        checkOutput("trmtOneCycle", trmt, 0);
        for (int i = 1; i < n; i++) tick();
        checkOutput("noEarlyPulse", {done, err}, 0);
        txDone = 1'b1;
        tick();
        checkOutput("done", done, 32'd1 << id);
        checkOutput("noErrWithDone", err, 0);
        checkOutput("busyLowAfterDone", busy, 0);
        if (dropTx) txDone = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        req     = 4'b0;
        reqData = {8'h43, 8'h32, 8'h21, 8'h10};
        txDone  = 1'b0;
        tick();
        tick();
        checkOutput("rstAckDoneErr", {ack, done, err}, 0);
        checkOutput("rstTrmtBusy", {trmt, busy}, 0);
        checkOutput("rstResp", resp, 8'h00);
        checkOutput("rstGnt", gntId, 0);
        rst = 1'b0;
        tick();

        $display("[TB] round-robin with all requesters active");
        applyStimulus(4'b1111);
        pushExp(2'd0, 8'h10); pushExp(2'd1, 8'h21); pushExp(2'd2, 8'h32); pushExp(2'd3, 8'h43);
        for (int i = 0; i < 4; i++) begin
            waitGrant();
            checkGrant();
            finishByte(gntId, 3, 1'b1);
        end
        applyStimulus(4'b1001);
        pushExp(2'd0, 8'h10); pushExp(2'd3, 8'h43);
        for (int i = 0; i < 2; i++) begin
            waitGrant();
            checkGrant();
            finishByte(gntId, 3, 1'b1);
        end

        $display("[TB] single request, latched data, short request ignored");
        reqData[23:16] = 8'hA5;
        applyStimulus(4'b0100);
        pushExp(2'd2, 8'hA5);
        waitGrant();
        checkGrant();
        tick();
        checkOutput("t1AckOneCycle", {ack, trmt}, 0);
        reqData[23:16] = 8'h00;
        req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checkOutput("t1NoEarlyDone", {done, err}, 0);
        txDone = 1'b1;
        tick();
        checkOutput("t1Done", done, 4'b0100);
        checkOutput("t1RespHeld", resp, 8'hA5);
        checkOutput("t1BusyLow", busy, 0);
        txDone = 1'b0;
        accum = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            accum = accum | {ack, done};
        end
        checkOutput("t1NoStaleGrant", accum, 0);
        reqData[23:16] = 8'h32;

        $display("[TB] timeout on requester 1");
        applyStimulus(4'b0010);
        pushExp(2'd1, 8'h21);
        waitGrant();
        checkGrant();
        accum = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            accum = accum | {done, err};
        end
        checkOutput("t3NoPulseBeforeTimeout", accum, 0);
        tick();
        checkOutput("t3Err", err, 4'b0010);
        checkOutput("t3NoDone", done, 0);
        checkOutput("t3Idle", busy, 0);
        tick();
        checkOutput("t3ErrOneCycle", err, 0);
        applyStimulus(4'b0011);
        pushExp(2'd0, 8'h10); pushExp(2'd1, 8'h21);
        for (int i = 0; i < 2; i++) begin
            waitGrant();
            checkGrant();
            finishByte(gntId, 2, 1'b1);
        end

        $display("[TB] tx_done held high across a new grant");
        txDone = 1'b1;
        tick();
        applyStimulus(4'b0010);
        pushExp(2'd1, 8'h21);
        waitGrant();
        checkGrant();
        accum = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            accum = accum | {done, err};
        end
        checkOutput("t4LevelIgnored", accum, 0);
        txDone = 1'b0;
        tick();
        checkOutput("t4NoDoneOnFall", done, 0);
        txDone = 1'b1;
        tick();
        checkOutput("t4DoneOnRise", done, 4'b0010);
        checkOutput("t4NoErr", err, 0);
        txDone = 1'b0;

        $display("[TB] reset during WAIT");
        applyStimulus(4'b0100);
        pushExp(2'd2, 8'h32);
        waitGrant();
        checkGrant();
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("t5TrmtBusy", {trmt, busy}, 0);
        checkOutput("t5Resp", resp, 0);
        checkOutput("t5Gnt", gntId, 0);
        tick();
        rst = 1'b0;
        accum = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            accum = accum | {done, err};
        end
        checkOutput("t5NoPulseAfterReset", accum, 0);
        applyStimulus(4'b1010);
        pushExp(2'd1, 8'h21); pushExp(2'd3, 8'h43);
        for (int i = 0; i < 2; i++) begin
            waitGrant();
            checkGrant();
            finishByte(gntId, 3, 1'b1);
        end

        $display("[TB] tx_done edge on the last timeout cycle");
        applyStimulus(4'b1000);
        pushExp(2'd3, 8'h43);
        waitGrant();
        checkGrant();
        finishByte(2'd3, 16, 1'b1);
        tick();
        checkOutput("t6NoLateErr", {done, err}, 0);
        checkOutput("sbDrained", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
